// File: rtl/ram_fifo_pkg.sv
// Shared types and parameter helpers for the RAM-backed synchronous FIFO.
// All width/ratio math is in narrow-word units: NW = min(write width, read width).
package ram_fifo_pkg;

    localparam int DEPTH_512  = 512;
    localparam int DEPTH_1024 = 1024;
    localparam int DEPTH_2048 = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } out_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int min_width(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Capacity in narrow words for a given write geometry.
    function automatic int narrow_depth(input int wr_w, input int rd_w, input int wr_depth);
        return wr_depth * (wr_w / min_width(wr_w, rd_w));
    endfunction

    function automatic bit legal_depth(input int depth);
        return (depth == DEPTH_512) || (depth == DEPTH_1024) || (depth == DEPTH_2048);
    endfunction

endpackage

// File: rtl/ram_fifo_sdp.sv
// Simple dual-port storage standing in for the RAM_RW macro: one write port and one
// non-registered read port, both on the fabric clock, full-word writes only.
module ram_fifo_sdp #(
    parameter int DW = 18,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // NOTE: the storage array is never reset; the FIFO pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram_fifo_sync.sv
// Single-clock FIFO on a simple dual-port RAM with 1/2/4 width conversion, optional
// first-word-fall-through output stage, level flags and overflow/underflow pulses.
module ram_fifo_sync
    import ram_fifo_pkg::*;
#(
    parameter int  WR_WIDTH  = 9,
    parameter int  RD_WIDTH  = 18,
    parameter int  WR_DEPTH  = 1024,
    parameter int  FWFT      = 0,
    parameter int  AF_THRESH = narrow_depth(WR_WIDTH, RD_WIDTH, WR_DEPTH) - 4,
    parameter int  AE_THRESH = 4,
    localparam int NW        = min_width(WR_WIDTH, RD_WIDTH),
    localparam int WR_R      = WR_WIDTH / NW,
    localparam int RD_R      = RD_WIDTH / NW,
    localparam int DN        = WR_DEPTH * WR_R,
    localparam int LW        = clog2(DN) + 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Flush,
    input  logic                Push,
    input  logic [WR_WIDTH-1:0] WD,
    input  logic                Pop,
    output logic [RD_WIDTH-1:0] RD,
    output logic                Full,
    output logic                Empty,
    output logic                Almost_Full,
    output logic                Almost_Empty,
    output logic [LW-1:0]       Fill_Level,
    output logic                Overflow,
    output logic                Underflow
);

    localparam int RAM_W  = max_width(WR_WIDTH, RD_WIDTH);
    localparam int RAM_D  = DN * NW / RAM_W;
    localparam int RAM_AW = clog2(RAM_D);
    localparam int WP_W   = clog2(WR_DEPTH);
    localparam int RP_W   = clog2(DN / RD_R);

    logic [WP_W-1:0]     wptr_q, wptr_d;
    logic [RP_W-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]       fill_q, fill_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                af_q, af_d;
    logic                ae_q, ae_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [RD_WIDTH-1:0] rd_q, rd_d;
    out_state_e          state_q, state_d;

    logic                push_ok;
    logic                pop_ok;
    logic                load;
    int                  fill_n;

    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [RAM_AW-1:0]   ram_raddr;
    logic [RAM_W-1:0]    ram_wdata;
    logic [RAM_W-1:0]    ram_rdata;
    logic [RD_WIDTH-1:0] ram_word;

    assign push_ok = Push && !full_q && !Flush;
    assign pop_ok  = Pop && !empty_q && !Flush;

    // Narrow writes into a wide RAM: earlier words wait in pack_q, the last one completes the row.
    if (RD_R > 1) begin : g_pack
        localparam int SUB_W = clog2(RD_R);
        logic [RD_WIDTH-WR_WIDTH-1:0] pack_q;
        logic [SUB_W-1:0]             sub;

        assign sub = wptr_q[SUB_W-1:0];

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                pack_q <= '0;
            end else if (push_ok && (sub != SUB_W'(RD_R - 1))) begin
                pack_q[sub*WR_WIDTH +: WR_WIDTH] <= WD;
            end
        end

        assign ram_we    = push_ok && (sub == SUB_W'(RD_R - 1));
        assign ram_waddr = wptr_q[WP_W-1:SUB_W];
        assign ram_wdata = {WD, pack_q};
    end else begin : g_direct_wr
        assign ram_we    = push_ok;
        assign ram_waddr = wptr_q;
        assign ram_wdata = WD;
    end

    if (WR_R > 1) begin : g_unpack
        localparam int SEL_W = clog2(WR_R);
        assign ram_raddr = rptr_q[RP_W-1:SEL_W];
        assign ram_word  = ram_rdata[rptr_q[SEL_W-1:0]*NW +: NW];
    end else begin : g_direct_rd
        assign ram_raddr = rptr_q;
        assign ram_word  = ram_rdata;
    end

    ram_fifo_sdp #(
        .DW (RAM_W),
        .AW (RAM_AW)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (FWFT == 0) begin
            load = pop_ok;
        end else begin
            case (state_q)
                IDLE: begin
                    if (int'(fill_q) >= RD_R) state_d = FETCH;
                end
                FETCH: begin
                    load    = 1'b1;
                    state_d = SHOW;
                end
                SHOW: begin
                    // Reload straight from RAM when another full word sits behind the head.
                    if (pop_ok) begin
                        if (int'(fill_q) - RD_R >= RD_R) load = 1'b1;
                        else                             state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fill_n  = int'(fill_q) + (push_ok ? WR_R : 0) - (pop_ok ? RD_R : 0);
        fill_d  = LW'(fill_n);
        full_d  = (DN - fill_n) < WR_R;
        empty_d = (FWFT == 0) ? (fill_n < RD_R) : (state_d != SHOW);
        af_d    = fill_n >= AF_THRESH;
        ae_d    = fill_n <= AE_THRESH;
        ovf_d   = Push && full_q && !Flush;
        unf_d   = Pop && empty_q && !Flush;
        wptr_d  = wptr_q + WP_W'(push_ok);
        rptr_d  = rptr_q + RP_W'(load);
        rd_d    = load ? ram_word : rd_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rd_q    <= '0;
            state_q <= IDLE;
        end else if (Flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rd_q    <= '0;
            state_q <= IDLE;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            rd_q    <= rd_d;
            state_q <= state_d;
        end
    end

    assign RD           = rd_q;
    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_Full  = af_q;
    assign Almost_Empty = ae_q;
    assign Fill_Level   = fill_q;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

endmodule

// File: tb/tb_ram_fifo_sync.sv
// Directed bench for ram_fifo_sync: four configurations run side by side on one clock,
// stepped through a linear sequence with hand-computed expectations.
module tb_ram_fifo_sync;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // u0: 9 -> 9, 1024 deep, standard read
    logic f0 = 0, p0 = 0, q0 = 0;
    logic [8:0]  wd0 = '0, rd0;
    logic full0, empty0, af0, ae0, ovf0, unf0;
    logic [10:0] fl0;
    // u1: 9 -> 18, 1024 deep, standard read
    logic f1 = 0, p1 = 0, q1 = 0;
    logic [8:0]  wd1 = '0;
    logic [17:0] rd1;
    logic full1, empty1, af1, ae1, ovf1, unf1;
    logic [10:0] fl1;
    // u2: 36 -> 9, 512 deep, standard read
    logic f2 = 0, p2 = 0, q2 = 0;
    logic [35:0] wd2 = '0;
    logic [8:0]  rd2;
    logic full2, empty2, af2, ae2, ovf2, unf2;
    logic [11:0] fl2;
    // u3: 18 -> 18, 1024 deep, first-word-fall-through
    logic f3 = 0, p3 = 0, q3 = 0;
    logic [17:0] wd3 = '0, rd3;
    logic full3, empty3, af3, ae3, ovf3, unf3;
    logic [10:0] fl3;

    ram_fifo_sync #(.WR_WIDTH(9), .RD_WIDTH(9), .WR_DEPTH(1024), .FWFT(0)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(f0), .Push(p0), .WD(wd0), .Pop(q0), .RD(rd0),
        .Full(full0), .Empty(empty0), .Almost_Full(af0), .Almost_Empty(ae0),
        .Fill_Level(fl0), .Overflow(ovf0), .Underflow(unf0));

    ram_fifo_sync #(.WR_WIDTH(9), .RD_WIDTH(18), .WR_DEPTH(1024), .FWFT(0)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(f1), .Push(p1), .WD(wd1), .Pop(q1), .RD(rd1),
        .Full(full1), .Empty(empty1), .Almost_Full(af1), .Almost_Empty(ae1),
        .Fill_Level(fl1), .Overflow(ovf1), .Underflow(unf1));

    ram_fifo_sync #(.WR_WIDTH(36), .RD_WIDTH(9), .WR_DEPTH(512), .FWFT(0)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(f2), .Push(p2), .WD(wd2), .Pop(q2), .RD(rd2),
        .Full(full2), .Empty(empty2), .Almost_Full(af2), .Almost_Empty(ae2),
        .Fill_Level(fl2), .Overflow(ovf2), .Underflow(unf2));

    ram_fifo_sync #(.WR_WIDTH(18), .RD_WIDTH(18), .WR_DEPTH(1024), .FWFT(1)) u3 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(f3), .Push(p3), .WD(wd3), .Pop(q3), .RD(rd3),
        .Full(full3), .Empty(empty3), .Almost_Full(af3), .Almost_Empty(ae3),
        .Fill_Level(fl3), .Overflow(ovf3), .Underflow(unf3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int bad;
        int bubbles;
        int fill_bad;
        int data_bad;
        logic [8:0]  v;
        logic [17:0] mq[$];

        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;

        check("rst_empty0", empty0, 1);
        check("rst_full0", full0, 0);
        check("rst_ae0", ae0, 1);
        check("rst_af0", af0, 0);
        check("rst_fill0", fl0, 0);
        check("rst_rd0", rd0, 0);
        check("rst_pulses0", {ovf0, unf0}, 0);
        check("rst_empty3", empty3, 1);

        // u0: fill 1024 words with flag boundaries along the way
        for (int i = 0; i < 1024; i++) begin
            p0 = 1'b1;
            wd0 = i[8:0];
            tick();
            if (i == 0) begin
                check("first_push_empty0", empty0, 0);
                check("first_push_fill0", fl0, 1);
            end
            if (i == 3)    check("ae_at_4", ae0, 1);
            if (i == 4)    check("ae_at_5", ae0, 0);
            if (i == 1018) check("af_at_1019", af0, 0);
            if (i == 1019) check("af_at_1020", af0, 1);
            if (i == 1022) check("full_at_1023", full0, 0);
        end
        check("full_at_1024", full0, 1);
        check("fill_at_1024", fl0, 1024);

        wd0 = 9'h1FF;
        tick();
        check("overflow_pulse", ovf0, 1);
        check("overflow_fill", fl0, 1024);
        p0 = 1'b0;
        tick();
        check("overflow_clear", ovf0, 0);

        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            q0 = 1'b1;
            tick();
            if (rd0 !== i[8:0]) bad++;
        end
        q0 = 1'b0;
        check("drain_seq0", bad, 0);
        check("drain_empty0", empty0, 1);
        check("drain_fill0", fl0, 0);

        q0 = 1'b1;
        tick();
        q0 = 1'b0;
        check("underflow_pulse", unf0, 1);
        check("underflow_fill", fl0, 0);
        check("underflow_rd_hold", rd0, 9'h1FF);
        tick();
        check("underflow_clear", unf0, 0);

        // Three more full fill/drain passes wrap both pointers repeatedly
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < 1024; i++) begin
                p0 = 1'b1;
                v = 9'((i * 7 + pass * 3 + 1) % 512);
                wd0 = v;
                tick();
            end
            p0 = 1'b0;
            check("wrap_full", full0, 1);
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                q0 = 1'b1;
                tick();
                v = 9'((i * 7 + pass * 3 + 1) % 512);
                if (rd0 !== v) bad++;
            end
            q0 = 1'b0;
            check("wrap_data", bad, 0);
        end

        // Simultaneous push and pop on a partly filled FIFO
        for (int i = 0; i < 5; i++) begin
            p0 = 1'b1;
            wd0 = 9'(10 + i);
            tick();
        end
        wd0 = 9'd15;
        q0 = 1'b1;
        tick();
        p0 = 1'b0;
        q0 = 1'b0;
        check("pushpop_fill", fl0, 5);
        check("pushpop_rd", rd0, 10);

        for (int i = 0; i < 295; i++) begin
            p0 = 1'b1;
            wd0 = 9'(i);
            tick();
        end
        p0 = 1'b0;
        check("pre_flush_fill", fl0, 300);

        f0 = 1'b1;
        p0 = 1'b1;
        q0 = 1'b1;
        tick();
        f0 = 1'b0;
        p0 = 1'b0;
        q0 = 1'b0;
        check("flush_fill", fl0, 0);
        check("flush_empty", empty0, 1);
        check("flush_ae", ae0, 1);
        check("flush_pulses", {ovf0, unf0}, 0);
        check("flush_rd", rd0, 0);

        f0 = 1'b1;
        q0 = 1'b1;
        tick();
        f0 = 1'b0;
        q0 = 1'b0;
        check("flush_blocks_underflow", unf0, 0);

        p0 = 1'b1;
        wd0 = 9'h0AA;
        tick();
        p0 = 1'b0;
        q0 = 1'b1;
        tick();
        q0 = 1'b0;
        check("post_flush_data", rd0, 9'h0AA);

        // u1: 9 -> 18 packing, first narrow word in the low half
        p1 = 1'b1;
        wd1 = 9'h001;
        tick();
        check("half_word_empty1", empty1, 1);
        check("half_word_fill1", fl1, 1);
        wd1 = 9'h002;
        tick();
        p1 = 1'b0;
        check("full_word_empty1", empty1, 0);
        check("full_word_fill1", fl1, 2);
        q1 = 1'b1;
        tick();
        q1 = 1'b0;
        check("pack_rd1", rd1, 18'h00401);
        check("pack_fill1", fl1, 0);
        check("pack_empty1", empty1, 1);

        p1 = 1'b1;
        wd1 = 9'h033;
        tick();
        p1 = 1'b0;
        q1 = 1'b1;
        tick();
        q1 = 1'b0;
        check("partial_underflow1", unf1, 1);
        check("partial_fill1", fl1, 1);
        check("partial_rd_hold1", rd1, 18'h00401);
        p1 = 1'b1;
        wd1 = 9'h044;
        tick();
        p1 = 1'b0;
        q1 = 1'b1;
        tick();
        q1 = 1'b0;
        check("pack2_rd1", rd1, 18'h08833);

        // u2: 36 -> 9, four 9-bit lanes read lowest first
        p2 = 1'b1;
        wd2 = {9'h088, 9'h077, 9'h066, 9'h055};
        tick();
        p2 = 1'b0;
        check("split_fill2", fl2, 4);
        check("split_empty2", empty2, 0);
        q2 = 1'b1;
        tick();
        check("split_rd2_0", rd2, 9'h055);
        tick();
        check("split_rd2_1", rd2, 9'h066);
        tick();
        check("split_rd2_2", rd2, 9'h077);
        tick();
        check("split_rd2_3", rd2, 9'h088);
        q2 = 1'b0;
        check("split_empty2_end", empty2, 1);
        check("split_fill2_end", fl2, 0);

        // u3: first-word-fall-through latency
        p3 = 1'b1;
        wd3 = 18'h00ABC;
        tick();
        p3 = 1'b0;
        check("fwft_empty_t", empty3, 1);
        tick();
        check("fwft_empty_t1", empty3, 1);
        tick();
        check("fwft_empty_t2", empty3, 0);
        check("fwft_rd_t2", rd3, 18'h00ABC);
        check("fwft_fill_t2", fl3, 1);

        p3 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wd3 = 18'(i);
            tick();
        end
        p3 = 1'b0;
        check("fwft_prefill", fl3, 4);
        check("fwft_head", rd3, 18'h00ABC);

        mq = {18'h00ABC, 18'h00001, 18'h00002, 18'h00003};
        bubbles = 0;
        fill_bad = 0;
        data_bad = 0;
        for (int k = 0; k < 100; k++) begin
            p3 = 1'b1;
            q3 = 1'b1;
            wd3 = 18'(18'h100 + k);
            tick();
            void'(mq.pop_front());
            mq.push_back(18'(18'h100 + k));
            if (empty3 !== 1'b0) bubbles++;
            if (fl3 !== 11'd4) fill_bad++;
            if (rd3 !== mq[0]) data_bad++;
        end
        p3 = 1'b0;
        q3 = 1'b0;
        check("stream_bubbles", bubbles, 0);
        check("stream_fill", fill_bad, 0);
        check("stream_data", data_bad, 0);

        q3 = 1'b1;
        tick();
        check("fwft_drain_1", rd3, 18'h00161);
        tick();
        check("fwft_drain_2", rd3, 18'h00162);
        tick();
        check("fwft_drain_3", rd3, 18'h00163);
        tick();
        q3 = 1'b0;
        check("fwft_drain_empty", empty3, 1);
        check("fwft_drain_fill", fl3, 0);
        check("fwft_drain_rd_hold", rd3, 18'h00163);

        // Reset asserted while the read of a freshly pushed word is in flight
        p3 = 1'b1;
        wd3 = 18'h00155;
        tick();
        p3 = 1'b0;
        tick();
        check("fetch_empty", empty3, 1);
        check("fetch_fill", fl3, 1);
        #2 Rst_n = 1'b0;
        #1;
        check("async_rst_rd", rd3, 0);
        check("async_rst_fill", fl3, 0);
        check("async_rst_empty", empty3, 1);
        check("async_rst_ae", ae3, 1);
        check("async_rst_full_af", {full3, af3}, 0);
        #2 Rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
